// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings: 4-bit operation codes consumed by alu_exec_unit
// and the 2-bit ALUOp values produced by the main decoder for the ALU controller.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b1111;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } exec_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W bits kept.
// start_i loads operands; last_o flags the cycle whose step produces the final product.
module alu_mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] product_o,
    output logic              last_o
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mplier_q;
    logic [CNT_W-1:0]  count_q;

    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product_o = acc_d;
    assign last_o    = (count_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= src1_i;
            mplier_q <= src2_i;
            count_q  <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with registered result and valid/ready on both sides.
// Define ALU_MUL_EN to enable the iterative multiply on code 1000.
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o
);

    exec_state_e       state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              accept;
    logic              mul_start;

    logic [DATA_W-1:0] sum, diff, alu_res;
    logic              add_ovf, sub_ovf, alu_ovf;

    assign sum     = src1_i + src2_i;
    assign diff    = src1_i - src2_i;
    assign add_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) && (sum[DATA_W-1] != src1_i[DATA_W-1]);
    // For SUB the effective second operand is ~B, so the sign test inverts.
    assign sub_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) && (diff[DATA_W-1] != src1_i[DATA_W-1]);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUCtrl_i)
            ALU_AND: alu_res = src1_i & src2_i;
            ALU_OR:  alu_res = src1_i | src2_i;
            ALU_XOR: alu_res = src1_i ^ src2_i;
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, diff[DATA_W-1] ^ sub_ovf};
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [DATA_W-1:0] mul_prod;
    logic              mul_last;

    alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .step_i    (state_q == ST_BUSY),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .product_o (mul_prod),
        .last_o    (mul_last)
    );
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: ready_o = 1'b1;
            ST_DONE: ready_o = ready_i;
            default: ready_o = 1'b0;
        endcase
        accept = valid_i && ready_o;

        if (state_q == ST_DONE && ready_i && !valid_i) begin
            state_d = ST_IDLE;
        end

        if (accept) begin
`ifdef ALU_MUL_EN
            if (ALUCtrl_i == ALU_MUL) begin
                mul_start = 1'b1;
                state_d   = ST_BUSY;
            end else begin
                result_d = alu_res;
                ovf_d    = alu_ovf;
                state_d  = ST_DONE;
            end
`else
            result_d = alu_res;
            ovf_d    = alu_ovf;
            state_d  = ST_DONE;
`endif
        end

`ifdef ALU_MUL_EN
        if (state_q == ST_BUSY && mul_last) begin
            result_d = mul_prod;
            ovf_d    = 1'b0;
            state_d  = ST_DONE;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign valid_o    = (state_q == ST_DONE);
    assign result_o   = result_q;
    assign zero_o     = (result_q == '0);
    assign overflow_o = ovf_q;

endmodule
